// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter with mult/div result buffer and busy scoreboard
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic [4:0]  chk_regA,
  input  logic [4:0]  chk_regB,
  input  logic [4:0]  chk_regD,
  output logic        stall_busy,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [4:0]    buf_rd   [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_next;
  logic          pipe_req;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // md_ready uses the pre-pop count, so a full buffer refuses even while draining
  assign md_ready   = (count < FULL);
  assign pipe_req   = pipe_we && (pipe_rd != 5'd0);
  assign push       = md_valid && md_ready && (md_rd != 5'd0);
  assign pop        = !pipe_req && (count != '0);
  assign head_rd    = buf_rd[head];
  assign head_data  = buf_data[head];
  assign stall_busy = busy[chk_regA] | busy[chk_regB] | busy[chk_regD];

  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_rd] = 1'b0;
    // a new issue to the same register outranks the retiring result
    if (md_issue && (md_issue_rd != 5'd0)) busy_next[md_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      buf_rd[tail]   <= md_rd;
      buf_data[tail] <= md_data;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      count <= count + CW'(push) - CW'(pop);
      busy  <= busy_next;
      if (pipe_req) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= pipe_rd;
        data_writeReg    <= pipe_data;
      end else if (pop) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= head_rd;
        data_writeReg    <= head_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
        ctrl_writeReg    <= 5'd0;
        data_writeReg    <= 32'd0;
      end
    end
  end

endmodule
